// File: rtl/rv_iommu_fq_writer_pkg.sv
// Shared definitions for the IOMMU fault-queue writer: record layout,
// queue geometry and the writer FSM encoding.
package rv_iommu_fq_writer_pkg;

    localparam int unsigned FQ_ENTRY_BYTES = 32;
    localparam int unsigned FQ_BEATS       = 4;
    localparam int unsigned FQ_BEAT_BYTES  = 8;
    localparam int unsigned FQ_REC_W       = FQ_ENTRY_BYTES * 8;
    localparam int unsigned FQ_BEAT_W      = $clog2(FQ_BEATS);
    localparam int unsigned FQ_ENTRY_SHIFT = $clog2(FQ_ENTRY_BYTES);
    localparam int unsigned FQ_BEAT_SHIFT  = $clog2(FQ_BEAT_BYTES);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        WAIT_RESP = 2'd2
    } fq_state_e;

    // Fault record as it sits in memory: beat 0 is bits [63:0].
    typedef struct packed {
        logic [63:0] iotval2;
        logic [63:0] iotval;
        logic [31:0] reserved;
        logic [31:0] custom;
        logic [23:0] did;
        logic [5:0]  ttyp;
        logic        priv;
        logic        pv;
        logic [19:0] pid;
        logic [11:0] cause;
    } fault_record_t;

    // Index mask for a queue of 2^(log2szm1+1) entries; log2szm1=31 yields all ones.
    function automatic logic [31:0] fq_mask(input logic [4:0] log2szm1);
        return (32'd2 << log2szm1) - 32'd1;
    endfunction

endpackage

// File: rtl/rv_iommu_fq_writer_fifo.sv
// Input record buffer: synchronous FIFO with flush, registered storage,
// read data presented from the head entry (no fall-through).
module rv_iommu_fq_writer_fifo #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  do_push, do_pop;

    assign full_o  = (cnt_q == DEPTH_CNT);
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; flush discards everything buffered.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is data only and needs no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/rv_iommu_fq_writer.sv
// IOMMU fault-queue writer: buffers incoming fault records, writes each to
// the in-memory queue tail as four 64-bit beats, and owns fqof/fqmf/fip.
module rv_iommu_fq_writer
    import rv_iommu_fq_writer_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 4,
    parameter int unsigned PPN_W     = 44,
    parameter int unsigned ADDR_W    = 56
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                fq_en_i,
    input  logic [PPN_W-1:0]    fq_base_ppn_i,
    input  logic [4:0]          fq_log2sz_i,
    input  logic [31:0]         fq_head_i,
    output logic [31:0]         fq_tail_o,
    input  logic                rec_valid_i,
    output logic                rec_ready_o,
    input  fault_record_t       rec_i,
    output logic                mem_req_o,
    input  logic                mem_gnt_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [63:0]         mem_wdata_o,
    output logic                mem_last_o,
    input  logic                mem_resp_valid_i,
    input  logic                mem_resp_err_i,
    output logic                fqof_o,
    output logic                fqmf_o,
    input  logic                fqof_clr_i,
    input  logic                fqmf_clr_i,
    output logic                fip_o,
    input  logic                fip_clr_i,
    output logic                busy_o
);

    localparam logic [FQ_BEAT_W-1:0] LAST_BEAT = FQ_BEAT_W'(FQ_BEATS - 1);

    fq_state_e              state_q, state_d;
    logic [FQ_BEAT_W-1:0]   beat_q, beat_d;
    logic [31:0]            tail_q, tail_d;
    fault_record_t          rec_q, rec_d;
    logic                   fqof_q, fqof_d;
    logic                   fqmf_q, fqmf_d;
    logic                   fip_q, fip_d;
    logic                   en_q;

    logic                   en_rise, en_fall;
    logic                   fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [FQ_REC_W-1:0]    fifo_rdata;
    logic [FQ_REC_W-1:0]    rec_bits;
    logic [31:0]            mask, tail_idx, tail_inc;
    logic                   q_full;
    logic                   of_set, mf_set, fip_set;
    logic [ADDR_W-1:0]      base_addr, entry_off, beat_off;

    // Enable edges come from a registered compare so software toggles are seen once.
    assign en_rise = fq_en_i & ~en_q;
    assign en_fall = ~fq_en_i & en_q;

    // Records offered while the queue is disabled are accepted and dropped.
    assign rec_ready_o = ~fifo_full;
    assign fifo_push   = rec_valid_i & rec_ready_o & fq_en_i;

    rv_iommu_fq_writer_fifo #(
        .DATA_WIDTH (FQ_REC_W),
        .DEPTH      (BUF_DEPTH)
    ) u_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (en_fall),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_i  (rec_i),
        .push_i  (fifo_push),
        .data_o  (fifo_rdata),
        .pop_i   (fifo_pop)
    );

    // Queue index arithmetic; head is re-read every check so software updates apply at once.
    assign mask     = fq_mask(fq_log2sz_i);
    assign tail_idx = tail_q & mask;
    assign tail_inc = (tail_q + 32'd1) & mask;
    assign q_full   = (tail_inc == (fq_head_i & mask));

    assign base_addr = ADDR_W'({fq_base_ppn_i, 12'h000});
    assign entry_off = ADDR_W'(tail_idx) << FQ_ENTRY_SHIFT;
    assign beat_off  = ADDR_W'(beat_q) << FQ_BEAT_SHIFT;
    assign rec_bits  = rec_q;

    // Beat outputs derive from held state, so they stay stable while ungranted.
    assign mem_req_o   = (state_q == WRITE);
    assign mem_last_o  = (state_q == WRITE) && (beat_q == LAST_BEAT);
    assign mem_addr_o  = (state_q == WRITE) ? (base_addr + entry_off + beat_off) : '0;
    assign mem_wdata_o = (state_q == WRITE) ? rec_bits[{beat_q, 6'd0} +: 64] : 64'd0;

    assign fq_tail_o = tail_q;
    assign fqof_o    = fqof_q;
    assign fqmf_o    = fqmf_q;
    assign fip_o     = fip_q;
    assign busy_o    = (state_q != IDLE) | ~fifo_empty;

    // Writer FSM next-state, tail update and status flag update.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        tail_d   = tail_q;
        rec_d    = rec_q;
        fifo_pop = 1'b0;
        of_set   = 1'b0;
        mf_set   = 1'b0;
        fip_set  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && fq_en_i) begin
                    fifo_pop = 1'b1;
                    // While overflow or memory-fault is pending, records are discarded silently.
                    if (!(fqof_q || fqmf_q)) begin
                        if (q_full) begin
                            of_set  = 1'b1;
                            fip_set = 1'b1;
                        end else begin
                            rec_d   = fault_record_t'(fifo_rdata);
                            beat_d  = '0;
                            state_d = WRITE;
                        end
                    end
                end
            end
            WRITE: begin
                if (mem_gnt_i) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (mem_resp_valid_i) begin
                    state_d = IDLE;
                    fip_set = 1'b1;
                    if (mem_resp_err_i) begin
                        mf_set = 1'b1;
                    end else if (fq_en_i) begin
                        // A write that finished after the queue was disabled does not publish.
                        tail_d = tail_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Set wins over a same-cycle software clear.
        fqof_d = of_set  | (fqof_q & ~fqof_clr_i);
        fqmf_d = mf_set  | (fqmf_q & ~fqmf_clr_i);
        fip_d  = fip_set | (fip_q  & ~fip_clr_i);

        // Re-enabling the queue restarts it from an empty, error-free state.
        if (en_rise) begin
            tail_d = '0;
            fqof_d = 1'b0;
            fqmf_d = 1'b0;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            beat_q  <= '0;
            tail_q  <= '0;
            fqof_q  <= 1'b0;
            fqmf_q  <= 1'b0;
            fip_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            tail_q  <= tail_d;
            fqof_q  <= fqof_d;
            fqmf_q  <= fqmf_d;
            fip_q   <= fip_d;
            en_q    <= fq_en_i;
        end
    end

    // Latched record being written; data only, so not reset.
    always_ff @(posedge clk_i) begin
        rec_q <= rec_d;
    end

endmodule

// File: tb/tb_rv_iommu_fq_writer.sv
module tb_rv_iommu_fq_writer;
    import rv_iommu_fq_writer_pkg::*;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          fq_en_i = 1'b0;
    logic [43:0]   fq_base_ppn_i = 44'h80000;
    logic [4:0]    fq_log2sz_i = 5'd3;
    logic [31:0]   fq_head_i = 32'd0;
    logic [31:0]   fq_tail_o;
    logic          rec_valid_i = 1'b0;
    logic          rec_ready_o;
    fault_record_t rec_i;
    logic          mem_req_o;
    logic          mem_gnt_i = 1'b0;
    logic [55:0]   mem_addr_o;
    logic [63:0]   mem_wdata_o;
    logic          mem_last_o;
    logic          mem_resp_valid_i = 1'b0;
    logic          mem_resp_err_i = 1'b0;
    logic          fqof_o, fqmf_o, fip_o, busy_o;
    logic          fqof_clr_i = 1'b0;
    logic          fqmf_clr_i = 1'b0;
    logic          fip_clr_i = 1'b0;

    int n_vec  = 0;
    int n_fail = 0;
    int rec_id = 0;

    always #5 clk = ~clk;

    rv_iommu_fq_writer dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .fq_en_i          (fq_en_i),
        .fq_base_ppn_i    (fq_base_ppn_i),
        .fq_log2sz_i      (fq_log2sz_i),
        .fq_head_i        (fq_head_i),
        .fq_tail_o        (fq_tail_o),
        .rec_valid_i      (rec_valid_i),
        .rec_ready_o      (rec_ready_o),
        .rec_i            (rec_i),
        .mem_req_o        (mem_req_o),
        .mem_gnt_i        (mem_gnt_i),
        .mem_addr_o       (mem_addr_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_last_o       (mem_last_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_err_i   (mem_resp_err_i),
        .fqof_o           (fqof_o),
        .fqmf_o           (fqmf_o),
        .fqof_clr_i       (fqof_clr_i),
        .fqmf_clr_i       (fqmf_clr_i),
        .fip_o            (fip_o),
        .fip_clr_i        (fip_clr_i),
        .busy_o           (busy_o)
    );

    typedef struct {
        logic [4:0]  log2sz;
        logic [31:0] head;
        logic [43:0] base;
        logic        err;
        logic        wr;
        logic [55:0] addr0;
        logic [31:0] tail;
        logic        of;
        logic        mf;
        logic        fip;
        logic        clr_of;
        logic        clr_mf;
        logic        clr_fip;
    } vec_t;

    vec_t        tbl[11];
    logic [255:0] R[6];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] make_rec(input int i);
        logic [31:0] t;
        t = i;
        return {32'h11110000, t, 32'h22220000, t, 32'h33330000, t, t, 20'h00000, 12'd13};
    endfunction

    function automatic logic [255:0] next_rec();
        rec_id++;
        return make_rec(rec_id);
    endfunction

    task automatic push(input logic [255:0] r);
        int n;
        n = 0;
        rec_valid_i = 1'b1;
        rec_i = r;
        while (!rec_ready_o && n < 300) begin tick(); n++; end
        chk("push_ready", rec_ready_o, 1);
        tick();
        rec_valid_i = 1'b0;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!mem_req_o && n < 300) begin tick(); n++; end
        chk("req_seen", mem_req_o, 1);
    endtask

    task automatic serve(input logic [55:0] a0, input logic [255:0] r, input int dly,
                         input logic err, input logic clr_fip);
        for (int b = 0; b < 4; b++) begin
            wait_req();
            chk("beat_addr", mem_addr_o, a0 + 56'(b * 8));
            chk("beat_data", mem_wdata_o, r[b*64 +: 64]);
            chk("beat_last", mem_last_o, (b == 3));
            repeat (dly) tick();
            if (dly > 0) chk("addr_hold", mem_addr_o, a0 + 56'(b * 8));
            mem_gnt_i = 1'b1;
            tick();
            mem_gnt_i = 1'b0;
        end
        chk("req_drop", mem_req_o, 0);
        mem_resp_valid_i = 1'b1;
        mem_resp_err_i   = err;
        fip_clr_i        = clr_fip;
        tick();
        mem_resp_valid_i = 1'b0;
        mem_resp_err_i   = 1'b0;
        fip_clr_i        = 1'b0;
    endtask

    task automatic no_write(input string nm);
        logic saw;
        saw = 1'b0;
        repeat (6) begin tick(); if (mem_req_o) saw = 1'b1; end
        chk(nm, saw, 0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        fq_log2sz_i = 5'd3;
        fq_head_i = 32'd0;
        fq_base_ppn_i = 44'h80000;
        fq_en_i = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] r;
        //                log2 head   base       err wr addr0             tail  of mf fip  cof cmf cfip
        tbl[0]  = '{5'd3, 32'd0, 44'h80000, 0, 1, 56'h0080000000, 32'd1, 0, 0, 1, 0, 0, 1};
        tbl[1]  = '{5'd0, 32'd1, 44'h80000, 0, 1, 56'h0080000020, 32'd0, 0, 0, 1, 0, 0, 1};
        tbl[2]  = '{5'd0, 32'd1, 44'h80000, 0, 0, 56'h0,          32'd0, 1, 0, 1, 0, 0, 1};
        tbl[3]  = '{5'd0, 32'd1, 44'h80000, 0, 0, 56'h0,          32'd0, 1, 0, 0, 1, 0, 0};
        tbl[4]  = '{5'd3, 32'd0, 44'h80000, 1, 1, 56'h0080000000, 32'd0, 0, 1, 1, 0, 0, 1};
        tbl[5]  = '{5'd3, 32'd0, 44'h80000, 0, 0, 56'h0,          32'd0, 0, 1, 0, 0, 0, 0};
        tbl[6]  = '{5'd3, 32'd0, 44'h80000, 0, 0, 56'h0,          32'd0, 0, 1, 0, 0, 1, 0};
        tbl[7]  = '{5'd3, 32'd0, 44'h80000, 0, 1, 56'h0080000000, 32'd1, 0, 0, 1, 0, 0, 1};
        tbl[8]  = '{5'd4, 32'd5, 44'h12345, 0, 1, 56'h0012345020, 32'd2, 0, 0, 1, 0, 0, 1};
        tbl[9]  = '{5'd1, 32'd3, 44'h12345, 0, 0, 56'h0,          32'd2, 1, 0, 1, 1, 0, 1};
        tbl[10] = '{5'd1, 32'd0, 44'h12345, 0, 1, 56'h0012345040, 32'd3, 0, 0, 1, 0, 0, 1};

        rec_i = '0;
        tick();
        tick();
        chk("rst_tail", fq_tail_o, 0);
        chk("rst_req", mem_req_o, 0);
        chk("rst_last", mem_last_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_wdata", mem_wdata_o, 0);
        chk("rst_of", fqof_o, 0);
        chk("rst_mf", fqmf_o, 0);
        chk("rst_fip", fip_o, 0);
        chk("rst_busy", busy_o, 0);
        rst_i = 1'b0;
        fq_en_i = 1'b1;
        tick();
        tick();

        // Table-driven single-record cases, applied in order on a persistent tail.
        for (int i = 0; i < 11; i++) begin
            fq_log2sz_i   = tbl[i].log2sz;
            fq_head_i     = tbl[i].head;
            fq_base_ppn_i = tbl[i].base;
            tick();
            r = next_rec();
            push(r);
            if (tbl[i].wr) serve(tbl[i].addr0, r, 0, tbl[i].err, 1'b0);
            else           no_write("no_write");
            tick();
            chk("vec_tail", fq_tail_o, tbl[i].tail);
            chk("vec_of", fqof_o, tbl[i].of);
            chk("vec_mf", fqmf_o, tbl[i].mf);
            chk("vec_fip", fip_o, tbl[i].fip);
            chk("vec_busy", busy_o, 0);
            fqof_clr_i = tbl[i].clr_of;
            fqmf_clr_i = tbl[i].clr_mf;
            fip_clr_i  = tbl[i].clr_fip;
            tick();
            fqof_clr_i = 1'b0;
            fqmf_clr_i = 1'b0;
            fip_clr_i  = 1'b0;
        end

        // Backpressure: slow grants, six records offered back to back.
        do_reset();
        for (int k = 0; k < 6; k++) R[k] = next_rec();
        fork
            begin : producer
                int stall_at;
                int n;
                stall_at = -1;
                rec_valid_i = 1'b1;
                for (int k = 0; k < 6; k++) begin
                    rec_i = R[k];
                    n = 0;
                    while (!rec_ready_o && n < 500) begin
                        if (stall_at < 0) stall_at = k;
                        tick();
                        n++;
                    end
                    chk("bp_ready", rec_ready_o, 1);
                    tick();
                end
                rec_valid_i = 1'b0;
                chk("bp_stall_at", stall_at, 5);
            end
            begin : consumer
                for (int k = 0; k < 6; k++)
                    serve(56'h0080000000 + 56'(k * 32), R[k], 5, 1'b0, 1'b0);
            end
        join
        tick();
        chk("bp_tail", fq_tail_o, 6);
        chk("bp_busy", busy_o, 0);

        // Disable mid-write: beats finish, tail holds, buffered records flushed.
        do_reset();
        r = next_rec();
        push(r);
        serve(56'h0080000000, r, 0, 1'b0, 1'b0);
        tick();
        chk("dis_pre_tail", fq_tail_o, 1);
        r = next_rec();
        push(r);
        push(next_rec());
        push(next_rec());
        for (int b = 0; b < 4; b++) begin
            wait_req();
            chk("dis_addr", mem_addr_o, 56'h0080000020 + 56'(b * 8));
            chk("dis_data", mem_wdata_o, r[b*64 +: 64]);
            if (b == 2) fq_en_i = 1'b0;
            mem_gnt_i = 1'b1;
            tick();
            mem_gnt_i = 1'b0;
        end
        chk("dis_req_drop", mem_req_o, 0);
        mem_resp_valid_i = 1'b1;
        tick();
        mem_resp_valid_i = 1'b0;
        chk("dis_tail", fq_tail_o, 1);
        no_write("dis_flushed");
        chk("dis_busy", busy_o, 0);
        fq_en_i = 1'b1;
        tick();
        tick();
        chk("en_tail", fq_tail_o, 0);

        // Re-enable after a memory fault clears the fault and the tail.
        r = next_rec();
        push(r);
        serve(56'h0080000000, r, 0, 1'b0, 1'b0);
        r = next_rec();
        push(r);
        serve(56'h0080000020, r, 0, 1'b1, 1'b0);
        tick();
        chk("mf_set", fqmf_o, 1);
        chk("mf_tail", fq_tail_o, 1);
        fq_en_i = 1'b0;
        tick();
        tick();
        fq_en_i = 1'b1;
        tick();
        tick();
        chk("reen_tail", fq_tail_o, 0);
        chk("reen_mf", fqmf_o, 0);
        chk("reen_of", fqof_o, 0);

        // fip clear coinciding with a successful response: set wins.
        fip_clr_i = 1'b1;
        tick();
        fip_clr_i = 1'b0;
        chk("fip_cleared", fip_o, 0);
        r = next_rec();
        push(r);
        serve(56'h0080000000, r, 0, 1'b0, 1'b1);
        tick();
        chk("setclr_fip", fip_o, 1);
        chk("setclr_tail", fq_tail_o, 1);

        // Synchronous reset in the middle of a write.
        r = next_rec();
        push(r);
        wait_req();
        chk("rw_addr0", mem_addr_o, 56'h0080000020);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        wait_req();
        rst_i = 1'b1;
        tick();
        chk("rw_req", mem_req_o, 0);
        chk("rw_last", mem_last_o, 0);
        chk("rw_addr", mem_addr_o, 0);
        chk("rw_tail", fq_tail_o, 0);
        chk("rw_fip", fip_o, 0);
        chk("rw_busy", busy_o, 0);
        rst_i = 1'b0;
        tick();
        chk("rw_ready", rec_ready_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
